// File: rtl/led_pkg.sv
// Shared definitions for the LED animation controller and the colour stage:
// mode encodings, default parameter values and the mode sequencing helper.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_STATIC = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_BLINK  = 2'd3
  } mode_t;

  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  localparam int DEFAULT_FRAMES_PER_STEP = 8;

  // The four modes form a ring, so a 2-bit increment wraps BLINK back to OFF.
  function automatic mode_t next_mode(input mode_t m);
    return mode_t'(m + 2'd1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Pushbutton conditioner: two-flop synchroniser, stability counter and a
// one-cycle press pulse when the accepted (active-low) level falls.
module key_debounce
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1, sync2;
  logic [CW-1:0] db_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
    end
  end

  // Any glitch back to the accepted level restarts the stability window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt <= '0;
      level  <= 1'b1;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (sync2 == level) begin
        db_cnt <= '0;
      end else if (db_cnt == LAST) begin
        db_cnt <= '0;
        level  <= sync2;
        press  <= ~sync2;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_anim_ctrl.sv
// LED animation controller: a debounced key cycles through the display modes,
// and frame markers from the tape driver pace the chase and blink animations.
module led_anim_ctrl
  import led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int FRAMES_PER_STEP = DEFAULT_FRAMES_PER_STEP
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_n,
  input  logic       frame,
  output logic       enable,
  output logic [2:0] cnt,
  output logic [1:0] mode
);

  localparam logic [7:0] LAST_FRAME = 8'(FRAMES_PER_STEP - 1);

  logic       key_level;
  logic       key_press;
  logic       press;
  logic       frame_q;
  logic       frame_tick;
  logic [7:0] frame_cnt;
  logic       step;
  logic       blink_phase;
  mode_t      mode_q;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_n),
    .level (key_level),
    .press (key_press)
  );

  assign press = key_press & ~key_level;

  // A frame marker may stay high for several cycles; only its rising edge counts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q    <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_q    <= frame;
      frame_tick <= frame & ~frame_q;
    end
  end

  assign step = frame_tick && (frame_cnt == LAST_FRAME);

  // A press wins over a coincident step: the mode moves on and the step is lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_OFF;
      enable      <= 1'b0;
      cnt         <= 3'd0;
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b1;
    end else if (press) begin
      mode_q      <= next_mode(mode_q);
      enable      <= (next_mode(mode_q) != MODE_OFF);
      frame_cnt   <= 8'd0;
      blink_phase <= 1'b1;
    end else if (mode_q == MODE_OFF) begin
      enable    <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      if (frame_tick) begin
        frame_cnt <= step ? 8'd0 : frame_cnt + 8'd1;
      end
      case (mode_q)
        MODE_CHASE: begin
          enable <= 1'b1;
          if (step) cnt <= cnt + 3'd1;
        end
        MODE_BLINK: begin
          if (step) begin
            blink_phase <= ~blink_phase;
            enable      <= ~blink_phase;
          end
        end
        default: enable <= 1'b1;
      endcase
    end
  end

  assign mode = mode_q;

endmodule

// File: tb/tb_led_anim_ctrl.sv
// Self-checking bench for led_anim_ctrl with short debounce and two frames per
// step; expectations are queued as stimulus is driven and popped when sampled.
module tb_led_anim_ctrl;

  logic       clk;
  logic       rst_n;
  logic       key_n;
  logic       frame;
  logic       enable;
  logic [2:0] cnt;
  logic [1:0] mode;

  typedef struct {
    string      tag;
    logic [5:0] val;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_checks = 0;
  int   n_pass   = 0;

  led_anim_ctrl #(
    .DEBOUNCE_CYCLES(4),
    .FRAMES_PER_STEP(2)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .frame  (frame),
    .enable (enable),
    .cnt    (cnt),
    .mode   (mode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic exp_t mk(input string tag, input int m, input int en, input int c);
    exp_t x;
    x.tag = tag;
    x.val = {2'(m), 1'(en), 3'(c)};
    return x;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse(input int width);
    frame = 1'b1;
    repeat (width) @(posedge clk);
    #1 frame = 1'b0;
    tick(2);
  endtask

  task automatic press_key();
    key_n = 1'b0;
    tick(12);
    key_n = 1'b1;
    tick(12);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    key_n = 1'b1;
    frame = 1'b0;
    exp_q.push_back(mk("reset", 0, 0, 0));
    #12;
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_first_press();
    key_n = 1'b0;
    exp_q.push_back(mk("press_pending", 0, 0, 0));
    exp_q.push_back(mk("press_static", 1, 1, 0));
    exp_q.push_back(mk("press_held_once", 1, 1, 0));
    tick(3);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(8);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(10);
    key_n = 1'b1;
    tick(12);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_bounce();
    exp_q.push_back(mk("bounce_rejected", 1, 1, 0));
    for (int i = 0; i < 10; i++) begin
      key_n = (i % 2 == 1);
      tick(2);
    end
    key_n = 1'b1;
    tick(12);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(1);
  endtask

  task automatic test_chase();
    int frames;
    int c;
    frames = 0;
    c = 0;
    exp_q.push_back(mk("enter_chase", 2, 1, 0));
    press_key();
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(1);
    for (int i = 1; i <= 26; i++) begin
      frames++;
      if (frames == 2) begin
        frames = 0;
        c = (c + 1) % 8;
      end
      exp_q.push_back(mk($sformatf("chase_pulse%0d", i), 2, 1, c));
      frame_pulse(1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({mode, enable, cnt} !== e.val)
        $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
      else n_pass++;
      tick(1);
    end
  endtask

  task automatic test_press_step_collision();
    exp_q.push_back(mk("pre_collision", 2, 1, 5));
    frame_pulse(1);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(1);
    // Press lands on the 7th edge after key_n falls; the frame tick lands there too.
    exp_q.push_back(mk("collision", 3, 1, 5));
    key_n = 1'b0;
    repeat (5) @(posedge clk);
    #1 frame = 1'b1;
    @(posedge clk);
    #1 frame = 1'b0;
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(4);
    key_n = 1'b1;
    tick(12);
  endtask

  task automatic test_blink();
    int frames;
    int en;
    frames = 0;
    en = 1;
    for (int i = 1; i <= 8; i++) begin
      frames++;
      if (frames == 2) begin
        frames = 0;
        en = 1 - en;
      end
      exp_q.push_back(mk($sformatf("blink_pulse%0d", i), 3, en, 5));
      frame_pulse((i == 7) ? 3 : 1);
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if ({mode, enable, cnt} !== e.val)
        $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
      else n_pass++;
      tick(1);
    end
  endtask

  task automatic test_off_and_reset();
    exp_q.push_back(mk("off_held", 0, 0, 5));
    press_key();
    frame_pulse(1);
    frame_pulse(1);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(1);
    exp_q.push_back(mk("static_kept_cnt", 1, 1, 5));
    press_key();
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(1);
    exp_q.push_back(mk("chase_again", 2, 1, 5));
    press_key();
    frame_pulse(1);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(1);
    exp_q.push_back(mk("async_reset", 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
  endtask

  task automatic test_reset_key_held();
    key_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(mk("no_press_on_release", 0, 0, 0));
    exp_q.push_back(mk("held_key_debounced", 1, 1, 0));
    tick(3);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    tick(10);
    @(negedge clk);
    e = exp_q.pop_front();
    n_checks++;
    if ({mode, enable, cnt} !== e.val)
      $display("[TB] FAIL %s: got %b want %b", e.tag, {mode, enable, cnt}, e.val);
    else n_pass++;
    key_n = 1'b1;
    tick(12);
  endtask

  initial begin
    test_reset();
    test_first_press();
    test_bounce();
    test_chase();
    test_press_step_collision();
    test_blink();
    test_off_and_reset();
    test_reset_key_held();
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("[TB] FAIL scoreboard_drain: %0d left, want 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
